// File: rtl/fpu_cmd_master.sv
// ----------------------------------------------------------------------------
// fpu_cmd_master
//
// Bus initiator for a memory-mapped FPU slave. Upstream {A, B, op} requests
// are queued in a small FIFO. For each request the FSM writes operand A
// (0x000), operand B (0x004) and the command word (0x008), one write-strobe
// cycle each. It then samples the FPU result register and returns the result
// with its op on a response channel.
//
// Handshake rule, used on both channels: a transfer happens on a rising edge
// where valid and ready are both high. The producer holds its payload stable
// while valid is high and ready is low. valid never waits on ready.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_a, i_req_b, i_req_op   request channel
//   o_rsp_valid/i_rsp_ready, o_rsp_result, o_rsp_op       response channel
//   o_fpu_cs, o_fpu_addr, o_fpu_wdata, i_fpu_rdata        FPU register bus
//   o_busy              FSM active or requests queued
//   o_state             current FSM state (debug)
// ----------------------------------------------------------------------------
module fpu_cmd_master #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  input  logic [1:0]  i_req_op,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_result,
  output logic [1:0]  o_rsp_op,
  output logic        o_fpu_cs,
  output logic [12:0] o_fpu_addr,
  output logic [31:0] o_fpu_wdata,
  input  logic [31:0] i_fpu_rdata,
  output logic        o_busy,
  output logic [2:0]  o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [12:0] ADDR_A   = 13'h000;
  localparam logic [12:0] ADDR_B   = 13'h004;
  localparam logic [12:0] ADDR_CMD = 13'h008;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_WR_B   = 3'd2,
    S_WR_CMD = 3'd3,
    S_RD     = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  // Each entry holds {op, a, b}.
  logic [65:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;

  logic          w_req_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_nz;
  logic [65:0]   w_head;
  logic [1:0]    w_head_op;
  logic [31:0]   w_head_a;
  logic [31:0]   w_head_b;

  // Ready depends only on occupancy. A pop in the same cycle does not make
  // room for a push when the FIFO is full. Ready is forced low while reset
  // is held.
  assign w_req_ready = !i_reset && (r_count < CW'(DEPTH));
  assign w_push      = i_req_valid && w_req_ready;
  assign w_fifo_nz   = (r_count != '0);

  // The FIFO pops only when the FSM takes a new job: from IDLE, or
  // straight from RESP when the current result is handed off.
  assign w_pop = w_fifo_nz &&
                 ((r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready));

  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[65:64];
  assign w_head_a  = w_head[63:32];
  assign w_head_b  = w_head[31:0];

  // The storage array needs no reset. Occupancy is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_req_op, i_req_a, i_req_b};
    end
  end

  // The pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // on their own.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered bus and response outputs
  // --------------------------------------------------------------------------
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic        r_fpu_cs;
  logic [12:0] r_fpu_addr;
  logic [31:0] r_fpu_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic [1:0]  r_rsp_op;

  // Bus outputs are registered. Each transition therefore loads the values
  // that belong to the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_fpu_cs     <= 1'b0;
      r_fpu_addr   <= '0;
      r_fpu_wdata  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_a         <= w_head_a;
            r_b         <= w_head_b;
            r_op        <= w_head_op;
            r_fpu_cs    <= 1'b1;
            r_fpu_addr  <= ADDR_A;
            r_fpu_wdata <= w_head_a;
            r_state     <= S_WR_A;
          end
        end

        S_WR_A: begin
          r_fpu_cs    <= 1'b1;
          r_fpu_addr  <= ADDR_B;
          r_fpu_wdata <= r_b;
          r_state     <= S_WR_B;
        end

        S_WR_B: begin
          r_fpu_cs    <= 1'b1;
          r_fpu_addr  <= ADDR_CMD;
          r_fpu_wdata <= {30'b0, r_op};
          r_state     <= S_WR_CMD;
        end

        // The FPU updates its result register on the edge that ends the
        // command write, so the result is valid throughout RD.
        S_WR_CMD: begin
          r_fpu_cs    <= 1'b0;
          r_fpu_addr  <= '0;
          r_fpu_wdata <= '0;
          r_state     <= S_RD;
        end

        S_RD: begin
          r_rsp_result <= i_fpu_rdata;
          r_rsp_op     <= r_op;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end

        // The result and op registers are written only in RD. They stay
        // stable while the consumer stalls.
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_fifo_nz) begin
              r_a         <= w_head_a;
              r_b         <= w_head_b;
              r_op        <= w_head_op;
              r_fpu_cs    <= 1'b1;
              r_fpu_addr  <= ADDR_A;
              r_fpu_wdata <= w_head_a;
              r_state     <= S_WR_A;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_fpu_cs    <= 1'b0;
          r_fpu_addr  <= '0;
          r_fpu_wdata <= '0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_op     = r_rsp_op;
  assign o_fpu_cs     = r_fpu_cs;
  assign o_fpu_addr   = r_fpu_addr;
  assign o_fpu_wdata  = r_fpu_wdata;
  assign o_busy       = (r_state != S_IDLE) || w_fifo_nz;
  assign o_state      = r_state;

endmodule

// File: tb/tb_fpu_cmd_master.sv
// ----------------------------------------------------------------------------
// Directed testbench for fpu_cmd_master. It includes a small behavioural FPU
// slave, which latches A and B and computes a result on each command write,
// using a table of known single-precision results.
// ----------------------------------------------------------------------------
module tb_fpu_cmd_master;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        fpu_cs;
  logic [12:0] fpu_addr;
  logic [31:0] fpu_wdata;
  logic [31:0] fpu_rdata;
  logic        busy;
  logic [2:0]  dbg_state;

  fpu_cmd_master #(.DEPTH(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_op     (req_op),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_op     (rsp_op),
    .o_fpu_cs     (fpu_cs),
    .o_fpu_addr   (fpu_addr),
    .o_fpu_wdata  (fpu_wdata),
    .i_fpu_rdata  (fpu_rdata),
    .o_busy       (busy),
    .o_state      (dbg_state)
  );

  // --------------------------------------------------------------------------
  // FPU slave model
  // --------------------------------------------------------------------------
  logic [31:0] fpu_ra  = '0;
  logic [31:0] fpu_rb  = '0;
  logic [31:0] fpu_res = '0;

  function automatic logic [31:0] fpu_calc(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [1:0]  op);
    logic [65:0] key;
    key = {op, a, b};
    case (key)
      {2'd1, 32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1+2
      {2'd2, 32'h3F80_0000, 32'h4000_0000}: return 32'hBF80_0000; // 1-2
      {2'd3, 32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000; // 2*3
      {2'd1, 32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000; // 2+2
      {2'd2, 32'h4040_0000, 32'h3F80_0000}: return 32'h4000_0000; // 3-1
      {2'd3, 32'h3F80_0000, 32'h3F80_0000}: return 32'h3F80_0000; // 1*1
      default: return (op == 2'd0) ? 32'h7FC0_0000 : 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (fpu_cs) begin
      case (fpu_addr)
        13'h000: fpu_ra  <= fpu_wdata;
        13'h004: fpu_rb  <= fpu_wdata;
        13'h008: fpu_res <= fpu_calc(fpu_ra, fpu_rb, fpu_wdata[1:0]);
        default: ;
      endcase
    end
  end
  assign fpu_rdata = fpu_res;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_rsp_op"},     64'(rsp_op),     64'd0);
    chk({tag, "_fpu_cs"},     64'(fpu_cs),     64'd0);
    chk({tag, "_fpu_addr"},   64'(fpu_addr),   64'd0);
    chk({tag, "_fpu_wdata"},  64'(fpu_wdata),  64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_req_ready"},  64'(req_ready),  64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, which starts "cycle 0")
  // --------------------------------------------------------------------------
  // Single request into an idle block, with a cycle-exact trace check.
  task automatic single_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [31:0] exp_res,
                           input string tag);
    chk({tag, "_busy_pre"}, 64'(busy), 64'd0);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk); // cycle 1
    req_valid = 1'b0;
    chk({tag, "_c1_cs"}, 64'(fpu_cs), 64'd0);
    @(negedge clk); // cycle 2
    chk({tag, "_c2_bus"}, {31'd0, fpu_cs, fpu_addr, fpu_wdata[18:0]},
        {31'd0, 1'b1, 13'h000, a[18:0]});
    chk({tag, "_c2_wdata"}, 64'(fpu_wdata), 64'(a));
    @(negedge clk); // cycle 3
    chk({tag, "_c3_addr"}, 64'({fpu_cs, fpu_addr}), 64'({1'b1, 13'h004}));
    chk({tag, "_c3_wdata"}, 64'(fpu_wdata), 64'(b));
    @(negedge clk); // cycle 4
    chk({tag, "_c4_addr"}, 64'({fpu_cs, fpu_addr}), 64'({1'b1, 13'h008}));
    chk({tag, "_c4_wdata"}, 64'(fpu_wdata), 64'({30'd0, op}));
    @(negedge clk); // cycle 5
    chk({tag, "_c5_bus"}, 64'({fpu_cs, fpu_addr, fpu_wdata}), 64'd0);
    chk({tag, "_c5_rsp_valid"}, 64'(rsp_valid), 64'd0);
    @(negedge clk); // cycle 6
    chk({tag, "_c6_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_c6_result"}, 64'(rsp_result), 64'(exp_res));
    chk({tag, "_c6_op"}, 64'(rsp_op), 64'(op));
    rsp_ready = 1'b1;
    @(negedge clk); // cycle 7
    rsp_ready = 1'b0;
    chk({tag, "_c7_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_c7_busy"}, 64'(busy), 64'd0);
  endtask

  // Wait (bounded) for rsp_valid; returns whether it was seen.
  task automatic wait_rsp(input int max_cycles, output logic seen);
    int n;
    n = 0;
    while (!rsp_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    seen = rsp_valid;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [31:0] ta [6];
  logic [31:0] tb [6];
  logic [1:0]  top[6];
  logic [31:0] tr [6];

  initial begin
    logic seen;
    int   t1;
    int   t2;
    int   idx;
    int   acc;
    logic [33:0] exp_v;

    ta[0] = 32'h3F80_0000; tb[0] = 32'h4000_0000; top[0] = 2'd1; tr[0] = 32'h4040_0000;
    ta[1] = 32'h3F80_0000; tb[1] = 32'h4000_0000; top[1] = 2'd2; tr[1] = 32'hBF80_0000;
    ta[2] = 32'h4000_0000; tb[2] = 32'h4040_0000; top[2] = 2'd3; tr[2] = 32'h40C0_0000;
    ta[3] = 32'h4000_0000; tb[3] = 32'h4000_0000; top[3] = 2'd1; tr[3] = 32'h4080_0000;
    ta[4] = 32'h4040_0000; tb[4] = 32'h3F80_0000; top[4] = 2'd2; tr[4] = 32'h4000_0000;
    ta[5] = 32'h3F80_0000; tb[5] = 32'h3F80_0000; top[5] = 2'd3; tr[5] = 32'h3F80_0000;

    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk_reset_values("rst");
    chk("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // ADD with full trace and latency.
    single_op(32'h3F80_0000, 32'h4000_0000, 2'd1, 32'h4040_0000, "add");

    // SUB then MUL back-to-back with rsp_ready held high.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_a = ta[1]; req_b = tb[1]; req_op = top[1];
    chk("b2b_ready0", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_a = ta[2]; req_b = tb[2]; req_op = top[2];
    chk("b2b_ready1", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(20, seen);
    t1 = cyc;
    chk("b2b_sub_seen", 64'(seen), 64'd1);
    chk("b2b_sub_result", 64'({rsp_op, rsp_result}), 64'({2'd2, 32'hBF80_0000}));
    @(negedge clk);
    wait_rsp(20, seen);
    t2 = cyc;
    chk("b2b_mul_seen", 64'(seen), 64'd1);
    chk("b2b_mul_result", 64'({rsp_op, rsp_result}), 64'({2'd3, 32'h40C0_0000}));
    chk("b2b_spacing", 64'(t2 - t1), 64'd5);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_busy_end", 64'(busy), 64'd0);

    // Unknown op 0 passes through; FPU returns NaN.
    single_op(32'h3F80_0000, 32'h3F80_0000, 2'd0, 32'h7FC0_0000, "op0");

    // Backpressure: req_valid held high, rsp_ready low.
    rsp_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1;
      req_a = ta[idx]; req_b = tb[idx]; req_op = top[idx];
      if (req_ready) begin
        acc++;
        exp_q.push_back({top[idx], tr[idx]});
        if (idx < 5) idx++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd5);
    chk("bp_req_ready_full", 64'(req_ready), 64'd0);
    chk("bp_rsp_valid_stall", 64'(rsp_valid), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);

    for (int k = 0; k < 5; k++) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
      wait_rsp(20, seen);
      chk("bp_rsp_seen", 64'(seen), 64'd1);
      chk("bp_result", 64'({rsp_op, rsp_result}), 64'(exp_v));
      @(negedge clk);
      chk("bp_stable_valid", 64'(rsp_valid), 64'd1);
      chk("bp_stable_result", 64'({rsp_op, rsp_result}), 64'(exp_v));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    chk("bp_busy_end", 64'(busy), 64'd0);
    chk("bp_rsp_valid_end", 64'(rsp_valid), 64'd0);

    // Reset during WR_B with two requests queued.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_a = ta[0]; req_b = tb[0]; req_op = top[0];
    @(negedge clk);
    req_a = ta[3]; req_b = tb[3]; req_op = top[3];
    @(negedge clk);
    req_a = ta[4]; req_b = tb[4]; req_op = top[4];
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_wr_b", 64'({fpu_cs, fpu_addr}), 64'({1'b1, 13'h004}));
    chk("rstmid_wr_b_data", 64'(fpu_wdata), 64'(tb[0]));
    reset = 1'b1;
    @(negedge clk);
    chk_reset_values("rstmid");
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_req_ready", 64'(req_ready), 64'd1);
    chk("rstmid_fifo_empty", 64'(busy), 64'd0);
    @(negedge clk);
    chk("rstmid_idle_cs", 64'(fpu_cs), 64'd0);
    chk("rstmid_idle_busy", 64'(busy), 64'd0);
    rsp_ready = 1'b0;
    single_op(32'h3F80_0000, 32'h4000_0000, 2'd1, 32'h4040_0000, "post_rst_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_cmd_master.md
# fpu_cmd_master

Bus initiator that drives the memory-mapped FPU register interface on behalf of an upstream requester. It accepts {A, B, op} requests over a valid/ready handshake, buffers them in a small FIFO, and performs the write sequence A → B → command. It then samples the FPU result register and returns it over a valid/ready response channel. It sits between a processing core or DMA engine and the FPU slave, and is the only agent driving the FPU's chip_select, addr and data_in.

## Interface
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears FIFO, FSM and all outputs.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; high when count < DEPTH.
- req_a  in  32  operand A, IEEE-754 single.
- req_b  in  32  operand B.
- req_op  in  2  1=ADD, 2=SUB, 3=MUL; 0 is forwarded as-is.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  32  FPU result word.
- rsp_op  out  2  echo of req_op for this result.
- fpu_cs  out  1  FPU chip_select; a write strobe, one cycle per register.
- fpu_addr  out  13  FPU register address.
- fpu_wdata  out  32  FPU write data (FPU data_in).
- fpu_rdata  in  32  FPU result (FPU data_out), always readable.
- busy  out  1  FSM not in IDLE or FIFO non-empty.

## Operation
- FIFO: push on req_valid && req_ready; pop only from IDLE or from RESP on handshake.
  - Push is gated by count alone, so no push while full even if a pop occurs the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states are IDLE, WR_A, WR_B, WR_CMD, RD, RESP.
- IDLE: if FIFO non-empty, pop the head into the work register {a, b, op} and go to WR_A.
- WR_A: fpu_cs=1, fpu_addr=0x000, fpu_wdata=a; go to WR_B.
- WR_B: fpu_cs=1, fpu_addr=0x004, fpu_wdata=b; go to WR_CMD.
- WR_CMD: fpu_cs=1, fpu_addr=0x008, fpu_wdata={30'b0, op}; go to RD.
  - The FPU updates its result register at this edge.
- RD: fpu_cs=0; capture fpu_rdata into rsp_result and op into rsp_op; go to RESP.
- RESP: rsp_valid=1. On rsp_ready:
  - if the FIFO is non-empty, pop and go to WR_A;
  - otherwise go to IDLE.
- Outside WR_* states: fpu_cs=0, fpu_addr=0, fpu_wdata=0.
- rsp_result and rsp_op are stable while rsp_valid is high and rsp_ready is low.
- The master performs no result interpretation; NaN (0x7FC00000) and other special values pass through unchanged.

## Timing
- Reset values: req_ready=0 during reset and 1 from the first cycle after; rsp_valid=0, rsp_result=0, rsp_op=0, fpu_cs=0, fpu_addr=0, fpu_wdata=0, busy=0; FIFO empty; state IDLE.
- Latency with an empty, idle block (request accepted in cycle 0):
  - IDLE pop in cycle 1;
  - WR_A, WR_B, WR_CMD in cycles 2, 3, 4;
  - RD in cycle 5;
  - rsp_valid high from cycle 6.
- Back-to-back throughput is one operation per 5 cycles (WR_A, WR_B, WR_CMD, RD, RESP) when rsp_ready is held high.
- Response backpressure stalls the FSM in RESP; the FIFO keeps filling. Up to DEPTH+1 requests are accepted: one in flight and DEPTH queued.
- Reset mid-operation takes effect at the next edge:
  - queued and in-flight requests are discarded;
  - fpu_cs is low from the cycle after reset;
  - partial FPU register writes are harmless because the FPU result changes only on a command write.

## Test plan
- ADD: A=0x3F800000, B=0x40000000, op=1 → rsp_result=0x40400000, rsp_op=1; rsp_valid in cycle 6; FPU write trace 0x000/0x004/0x008 in cycles 2-4.
- SUB and MUL back-to-back, rsp_ready=1:
  - 0x3F800000−0x40000000 → 0xBF800000;
  - 0x40000000×0x40400000 → 0x40C00000;
  - second rsp_valid exactly 5 cycles after the first.
- Invalid op=0, A=B=0x3F800000 → rsp_result=0x7FC00000, rsp_op=0.
- Backpressure with DEPTH=4 and rsp_ready=0 while req_valid is held high → exactly 5 accepts, then req_ready=0. Release rsp_ready → 5 in-order results, each stable while stalled; busy falls after the last handshake.
- Reset asserted during WR_B with 2 requests queued:
  - next cycle all outputs are at reset values and the FIFO is empty;
  - a new ADD issued afterwards returns the correct result with the 6-cycle latency.
